// File: rtl/krnl_axi_rd_master.sv
// AXI4 read master: splits a byte range into 4KB-safe bursts and streams the data out.
// Define RD_MASTER_PERF_EN to add the perf_cycles/perf_stall counters.
module krnl_axi_rd_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_MAX_BURST_LEN    = 64,
   parameter int C_MAX_OUTSTANDING  = 8,
   parameter int C_XFER_SIZE_WIDTH  = 32
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst_n,
   input  logic                          ctrl_start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
   output logic                          ctrl_done,
   output logic                          ctrl_err,
   output logic                          m_axi_ARVALID,
   input  logic                          m_axi_ARREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_ARADDR,
   output logic [7:0]                    m_axi_ARLEN,
   output logic [2:0]                    m_axi_ARSIZE,
   output logic [1:0]                    m_axi_ARBURST,
   input  logic                          m_axi_RVALID,
   output logic                          m_axi_RREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_RDATA,
   input  logic                          m_axi_RLAST,
   input  logic [1:0]                    m_axi_RRESP,
`ifdef RD_MASTER_PERF_EN
   output logic [31:0]                   perf_cycles,
   output logic [31:0]                   perf_stall,
`endif
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                          m_axis_tlast
);

   localparam int BPB = C_M_AXI_DATA_WIDTH / 8;
   localparam int LG  = $clog2(BPB);
   localparam int AW  = C_M_AXI_ADDR_WIDTH;
   localparam int XW  = C_XFER_SIZE_WIDTH + 1;
   localparam int OW  = $clog2(C_MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAXO = OW'(C_MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  addr_q;
   logic [AW-1:0]  araddr_q;
   logic [7:0]     arlen_q;
   logic           arvalid_q;
   logic           done_q;
   logic           err_q;
   logic [XW-1:0]  ar_rem_q;
   logic [XW-1:0]  total_q;
   logic [XW-1:0]  r_cnt_q;
   logic [OW-1:0]  out_q;

   logic [XW-1:0]  n_beats;
   logic [12:0]    room_bytes;
   logic [12:0]    room_beats;
   logic [8:0]     burst_len;
   logic           active;
   logic           start_acc;
   logic           issue;
   logic           ar_acc;
   logic           r_acc;
   logic           rlast_acc;
   logic           last_beat;

   assign n_beats    = ({1'b0, ctrl_xfer_size_in_bytes} + XW'(BPB - 1)) >> LG;
   assign room_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
   assign room_beats = room_bytes >> LG;

   // Burst never exceeds the max length, the remaining beats or the 4KB page.
   always_comb begin
      burst_len = 9'(C_MAX_BURST_LEN);
      if (ar_rem_q < XW'(burst_len))
         burst_len = ar_rem_q[8:0];
      if (room_beats < 13'(burst_len))
         burst_len = room_beats[8:0];
   end

   assign active    = (state_q == RUN) || (state_q == DRAIN);
   assign start_acc = ctrl_start && (state_q == IDLE);
   assign issue     = (state_q == RUN) && !arvalid_q &&
                      (ar_rem_q != '0) && (out_q < MAXO);
   assign ar_acc    = arvalid_q && m_axi_ARREADY;
   assign r_acc     = m_axi_RVALID && m_axi_RREADY;
   assign rlast_acc = r_acc && m_axi_RLAST;
   assign last_beat = (r_cnt_q == total_q - XW'(1));

   assign m_axi_ARVALID = arvalid_q;
   assign m_axi_ARADDR  = araddr_q;
   assign m_axi_ARLEN   = arlen_q;
   assign m_axi_ARSIZE  = 3'(LG);
   assign m_axi_ARBURST = 2'b01;
   assign m_axi_RREADY  = m_axis_tready && active;
   assign m_axis_tvalid = m_axi_RVALID && active;
   assign m_axis_tdata  = m_axi_RDATA;
   assign m_axis_tlast  = m_axis_tvalid && last_beat;
   assign ctrl_done     = done_q;
   assign ctrl_err      = err_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (ctrl_start)
               state_d = (n_beats == '0) ? DONE : RUN;
         end
         RUN: begin
            if (ar_acc && (ar_rem_q == '0))
               state_d = DRAIN;
         end
         DRAIN: begin
            if ((r_acc && last_beat) || (r_cnt_q == total_q))
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arvalid_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ar_rem_q  <= '0;
         total_q   <= '0;
         r_cnt_q   <= '0;
         out_q     <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == DONE);
         if (start_acc) begin
            addr_q   <= ctrl_addr_offset;
            ar_rem_q <= n_beats;
            total_q  <= n_beats;
            r_cnt_q  <= '0;
            err_q    <= 1'b0;
            out_q    <= '0;
         end else begin
            if (issue) begin
               arvalid_q <= 1'b1;
               araddr_q  <= addr_q;
               arlen_q   <= 8'(burst_len - 9'd1);
               addr_q    <= addr_q + (AW'(burst_len) << LG);
               ar_rem_q  <= ar_rem_q - XW'(burst_len);
            end else if (ar_acc) begin
               arvalid_q <= 1'b0;
            end
            if (ar_acc && !rlast_acc)
               out_q <= out_q + OW'(1);
            else if (!ar_acc && rlast_acc)
               out_q <= out_q - OW'(1);
            if (r_acc) begin
               r_cnt_q <= r_cnt_q + XW'(1);
               if (m_axi_RRESP != 2'b00)
                  err_q <= 1'b1;
            end
         end
      end
   end

`ifdef RD_MASTER_PERF_EN
   logic [31:0] cyc_q, stall_q;

   assign perf_cycles = cyc_q;
   assign perf_stall  = stall_q;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         cyc_q   <= '0;
         stall_q <= '0;
      end else if (start_acc) begin
         cyc_q   <= '0;
         stall_q <= '0;
      end else begin
         if ((state_q != IDLE) && (cyc_q != '1))
            cyc_q <= cyc_q + 32'd1;
         if (m_axis_tvalid && !m_axis_tready && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
      end
   end
`endif

endmodule
